// File: rtl/latch_bank_arbiter.sv
// rtl/latch_bank_arbiter.sv - round-robin two-requester arbiter for a shared bank of 1-bit latch cells
//
// Two requesters (A, B) share one bank of CELLS latch cells. A granted write
// drives LatchData, pulses WriteEdge[addr] for STROBE_CYCLES cycles and holds
// the data one more cycle. A granted read pulses ReadEdge[addr] for
// STROBE_CYCLES cycles, then samples LatchOut[addr] in a capture cycle. Each
// transaction ends with a one-cycle Ack to the granted requester.
//
// Optional feature macro: LATCH_ARB_VERIFY_EN
//   When defined, every write is followed by a read-back of the same cell.
//   VerifyErr pulses with the Ack if the read-back differs from the write data.
//
// Ports:
//   Clock               in   rising-edge clock
//   Reset               in   synchronous active-high reset
//   ReqA/ReqB           in   transaction request, held until the matching Ack
//   WrA/WrB             in   1 = write, 0 = read
//   AddrA/AddrB         in   target cell index
//   DataA/DataB         in   write data
//   AckA/AckB           out  one-cycle completion pulse
//   RdData              out  last captured cell value, valid from the Ack cycle
//   Busy                out  high whenever a transaction is in progress
//   VerifyErr           out  write-verify mismatch pulse, coincident with Ack
//   LatchData           out  shared data input to all cells
//   WriteEdge/ReadEdge  out  per-cell strobes, one-hot or zero
//   LatchOut            in   data output of each cell

module latch_bank_arbiter #(
    parameter int CELLS         = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       ReqA,
    input  logic                       ReqB,
    input  logic                       WrA,
    input  logic                       WrB,
    input  logic [$clog2(CELLS)-1:0]   AddrA,
    input  logic [$clog2(CELLS)-1:0]   AddrB,
    input  logic                       DataA,
    input  logic                       DataB,
    output logic                       AckA,
    output logic                       AckB,
    output logic                       RdData,
    output logic                       Busy,
    output logic                       VerifyErr,
    output logic                       LatchData,
    output logic [CELLS-1:0]           WriteEdge,
    output logic [CELLS-1:0]           ReadEdge,
    input  logic [CELLS-1:0]           LatchOut
);

    localparam int AW = $clog2(CELLS);
    // Counter only needs to hold STROBE_CYCLES-1; a single-cycle strobe still gets one bit.
    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYCLES - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] WSTROBE = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] RSTROBE = 3'd4;
    localparam logic [2:0] CAPTURE = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]    state;
    logic [2:0]    nextState;
    logic [CW-1:0] strobeCnt;
    logic          grantA;
    logic          opWr;
    logic [AW-1:0] addrReg;
    logic          lastGrantB;
    logic          latchDataReg;
    logic          rdDataReg;

    logic          anyReq;
    logic          pickA;
    logic          selWr;
    logic [AW-1:0] selAddr;
    logic          selData;
    logic [CELLS-1:0] cellSel;

    // A wins when alone, or on a tie when B was granted last.
    assign anyReq  = ReqA || ReqB;
    assign pickA   = ReqA && (!ReqB || lastGrantB);
    assign selWr   = pickA ? WrA   : WrB;
    assign selAddr = pickA ? AddrA : AddrB;
    assign selData = pickA ? DataA : DataB;

    assign cellSel = {{(CELLS-1){1'b0}}, 1'b1} << addrReg;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = selWr ? SETUP : RSTROBE;
            SETUP:   nextState = WSTROBE;
            WSTROBE: if (strobeCnt == '0) nextState = HOLD;
            HOLD: begin
`ifdef LATCH_ARB_VERIFY_EN
                nextState = RSTROBE;
`else
                nextState = DONE;
`endif
            end
            RSTROBE: if (strobeCnt == '0) nextState = CAPTURE;
            CAPTURE: nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            strobeCnt    <= CNT_LOAD;
            grantA       <= 1'b0;
            opWr         <= 1'b0;
            addrReg      <= '0;
            lastGrantB   <= 1'b1;
            latchDataReg <= 1'b0;
            rdDataReg    <= 1'b0;
        end else begin
            state <= nextState;

            // Reload on every state change so each strobe phase lasts exactly
            // STROBE_CYCLES cycles; counting stops at zero rather than wrapping.
            if (nextState != state) begin
                strobeCnt <= CNT_LOAD;
            end else if (strobeCnt != '0) begin
                strobeCnt <= strobeCnt - 1'b1;
            end

            if (state == IDLE && anyReq) begin
                grantA     <= pickA;
                lastGrantB <= !pickA;
                opWr       <= selWr;
                addrReg    <= selAddr;
                // LatchData only moves when a write is granted, so it is
                // already stable in SETUP and holds between writes.
                if (selWr) begin
                    latchDataReg <= selData;
                end
            end

            // Registering here makes the value visible in the DONE/Ack cycle.
            if (state == CAPTURE) begin
                rdDataReg <= LatchOut[addrReg];
            end
        end
    end

`ifdef LATCH_ARB_VERIFY_EN
    logic verifyErrReg;

    // LatchData still holds the write data during the read-back.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            verifyErrReg <= 1'b0;
        end else begin
            verifyErrReg <= (state == CAPTURE) && opWr && (LatchOut[addrReg] != latchDataReg);
        end
    end

    assign VerifyErr = verifyErrReg;
`else
    assign VerifyErr = 1'b0;
`endif

    assign Busy      = (state != IDLE);
    assign AckA      = (state == DONE) && grantA;
    assign AckB      = (state == DONE) && !grantA;
    assign RdData    = rdDataReg;
    assign LatchData = latchDataReg;
    assign WriteEdge = (state == WSTROBE) ? cellSel : '0;
    assign ReadEdge  = (state == RSTROBE || state == CAPTURE) ? cellSel : '0;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb/tb_latch_bank_arbiter.sv - self-checking bench for latch_bank_arbiter with a transaction-level model

module tb_latch_bank_arbiter;

    localparam int CELLS = 8;
    localparam int S     = 2;
    localparam int AW    = 3;
`ifdef LATCH_ARB_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam logic [CELLS-1:0] INIT_MEM = 8'h5A;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic ReqA = 1'b0, ReqB = 1'b0, WrA = 1'b0, WrB = 1'b0, DataA = 1'b0, DataB = 1'b0;
    logic [AW-1:0] AddrA = '0, AddrB = '0;
    logic AckA, AckB, RdData, Busy, VerifyErr, LatchData;
    logic [CELLS-1:0] WriteEdge, ReadEdge, LatchOut;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    latch_bank_arbiter #(.CELLS(CELLS), .STROBE_CYCLES(S)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqA(ReqA), .ReqB(ReqB), .WrA(WrA), .WrB(WrB),
        .AddrA(AddrA), .AddrB(AddrB), .DataA(DataA), .DataB(DataB),
        .AckA(AckA), .AckB(AckB), .RdData(RdData), .Busy(Busy),
        .VerifyErr(VerifyErr), .LatchData(LatchData),
        .WriteEdge(WriteEdge), .ReadEdge(ReadEdge), .LatchOut(LatchOut)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Latch bank environment: a cell follows LatchData while its WriteEdge is high.
    logic [CELLS-1:0] envMem;
    logic envReady = 1'b0;
    logic [CELLS-1:0] stuckMask = '0;

    always @(posedge Clock) begin
        if (!envReady) begin
            envMem   <= INIT_MEM;
            envReady <= 1'b1;
        end else begin
            for (int i = 0; i < CELLS; i++)
                if (WriteEdge[i] === 1'b1) envMem[i] <= LatchData;
        end
    end

    assign LatchOut = envMem & ~stuckMask;

    // Transaction-level model: k counts cycles since acceptance (k=0).
    bit mValid = 0, mActive = 0, mLastB = 1, mGrantA = 0, mWr = 0, mData = 0;
    bit mLatch = 0, mRd = 0, captured = 0;
    bit eWE, eRE, eAck, eVE;
    int mK = 0, len = 0;
    logic [AW-1:0] mAddr = '0;
    logic [CELLS-1:0] mMem = '0;
    logic [CELLS-1:0] oneHot;

    function automatic int txnLen(input bit wr);
        if (wr) return VERIFY ? 2*S + 4 : S + 3;
        return S + 2;
    endfunction

    always @(negedge Clock) begin
        cyc++;
        eWE = 0; eRE = 0; eAck = 0; eVE = 0;
        oneHot = '0;
        oneHot[mAddr] = 1'b1;
        if (mActive) begin
            len = txnLen(mWr);
            if (mWr && mK == 1) mLatch = mData;
            if (mWr && mK == 2) mMem[mAddr] = mData;
            eWE = mWr && mK >= 2 && mK <= S + 1;
            eRE = (!mWr && mK <= S + 1) || (VERIFY && mWr && mK >= S + 3 && mK <= 2*S + 3);
            if (mK == len) begin
                eAck = 1;
                if (!mWr || VERIFY) begin
                    captured = mMem[mAddr] & ~stuckMask[mAddr];
                    mRd = captured;
                    eVE = mWr && (captured != mData);
                end
            end
        end
        if (mValid) begin
            check("model_busy",      64'(Busy),      64'(mActive));
            check("model_writeedge", 64'(WriteEdge), 64'(eWE ? oneHot : '0));
            check("model_readedge",  64'(ReadEdge),  64'(eRE ? oneHot : '0));
            check("model_acka",      64'(AckA),      64'(eAck && mGrantA));
            check("model_ackb",      64'(AckB),      64'(eAck && !mGrantA));
            check("model_rddata",    64'(RdData),    64'(mRd));
            check("model_latchdata", 64'(LatchData), 64'(mLatch));
            check("model_verifyerr", 64'(VerifyErr), 64'(eVE));
        end
        if (Reset) begin
            if (!mValid) mMem = INIT_MEM;
            mValid = 1; mActive = 0; mLastB = 1; mLatch = 0; mRd = 0;
        end else if (mActive) begin
            if (mK == len) mActive = 0;
            else mK++;
        end else if (ReqA || ReqB) begin
            mGrantA = ReqA && (!ReqB || mLastB);
            mLastB  = !mGrantA;
            mWr     = mGrantA ? WrA : WrB;
            mAddr   = mGrantA ? AddrA : AddrB;
            mData   = mGrantA ? DataA : DataB;
            mActive = 1;
            mK      = 1;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    int ackCount;
    int grantSeq[3];

    initial begin
        repeat (3) tick();
        Reset = 1'b0;

        // Reset state
        @(negedge Clock);
        check("rst_busy",      64'(Busy),      64'(0));
        check("rst_writeedge", 64'(WriteEdge), 64'(0));
        check("rst_readedge",  64'(ReadEdge),  64'(0));
        check("rst_rddata",    64'(RdData),    64'(0));
        check("rst_latchdata", 64'(LatchData), 64'(0));
        check("rst_acks",      64'({AckA, AckB}), 64'(0));
        tick();

        // Write 1 to cell 3 from A
        ReqA = 1; WrA = 1; AddrA = 3; DataA = 1;
        for (int n = 0; n <= 6; n++) begin
            if (n == 6) ReqA = 0;
            @(negedge Clock);
            check("wr_writeedge", 64'(WriteEdge), 64'((n == 2 || n == 3) ? 8'h08 : 8'h00));
            check("wr_busy",      64'(Busy),      64'(n >= 1 && n <= 5));
            check("wr_acka",      64'(AckA),      64'(n == 5));
            tick();
        end

        // Read cell 3 from B
        ReqB = 1; WrB = 0; AddrB = 3;
        for (int n = 0; n <= 5; n++) begin
            if (n == 5) ReqB = 0;
            @(negedge Clock);
            check("rd_readedge", 64'(ReadEdge), 64'((n >= 1 && n <= 3) ? 8'h08 : 8'h00));
            check("rd_ackb",     64'(AckB),     64'(n == 4));
            if (n == 4) check("rd_rddata", 64'(RdData), 64'(1));
            tick();
        end

        // Requester drops Req right after acceptance; Ack still issued
        ReqA = 1; WrA = 1; AddrA = 1; DataA = 0;
        for (int n = 0; n <= 6; n++) begin
            if (n == 1) ReqA = 0;
            @(negedge Clock);
            check("drop_acka", 64'(AckA), 64'(n == 5));
            tick();
        end

        // Round-robin ties right after reset: A, B, A
        doReset();
        ReqA = 1; WrA = 0; AddrA = 0;
        ReqB = 1; WrB = 0; AddrB = 7;
        ackCount = 0;
        for (int n = 0; n < 40 && ackCount < 3; n++) begin
            @(negedge Clock);
            if (AckA === 1'b1) begin grantSeq[ackCount] = 1; ackCount++; end
            else if (AckB === 1'b1) begin grantSeq[ackCount] = 2; ackCount++; end
            tick();
        end
        ReqA = 0; ReqB = 0;
        check("rr_ack_count", 64'(ackCount), 64'(3));
        if (ackCount == 3) begin
            check("rr_grant0", 64'(grantSeq[0]), 64'(1));
            check("rr_grant1", 64'(grantSeq[1]), 64'(2));
            check("rr_grant2", 64'(grantSeq[2]), 64'(1));
        end
        tick();

        // Reset during WSTROBE aborts the write
        ReqA = 1; WrA = 1; AddrA = 6; DataA = 0;
        for (int n = 0; n <= 8; n++) begin
            if (n == 2) Reset = 1;
            if (n == 3) begin Reset = 0; ReqA = 0; end
            @(negedge Clock);
            if (n == 2) check("abort_in_wstrobe", 64'(WriteEdge), 64'(8'h40));
            if (n >= 3) begin
                check("abort_writeedge", 64'(WriteEdge), 64'(0));
                check("abort_no_acka",   64'(AckA),      64'(0));
                check("abort_busy",      64'(Busy),      64'(0));
            end
            tick();
        end
        ReqB = 1; WrB = 0; AddrB = 6;
        for (int n = 0; n <= 5; n++) begin
            if (n == 5) ReqB = 0;
            @(negedge Clock);
            check("after_abort_ackb", 64'(AckB), 64'(n == 4));
            if (n == 4) check("after_abort_rddata", 64'(RdData), 64'(0));
            tick();
        end

`ifdef LATCH_ARB_VERIFY_EN
        // Verify write to a cell stuck at 0
        stuckMask = 8'h20;
        ReqA = 1; WrA = 1; AddrA = 5; DataA = 1;
        for (int n = 0; n <= 9; n++) begin
            if (n == 9) ReqA = 0;
            @(negedge Clock);
            check("verify_acka", 64'(AckA), 64'(n == 8));
            if (n == 8) begin
                check("verify_err",    64'(VerifyErr), 64'(1));
                check("verify_rddata", 64'(RdData),    64'(0));
            end
            tick();
        end
        stuckMask = 8'h00;
`endif

        // Randomized traffic with occasional resets and abandoned requests
        for (int c = 0; c < 4000; c++) begin
            if (AckA === 1'b1) ReqA = 0;
            else if (ReqA && $urandom_range(0, 40) == 0) ReqA = 0;
            else if (!ReqA && $urandom_range(0, 2) == 0) begin
                ReqA = 1; WrA = 1'($urandom); AddrA = AW'($urandom); DataA = 1'($urandom);
            end
            if (AckB === 1'b1) ReqB = 0;
            else if (ReqB && $urandom_range(0, 40) == 0) ReqB = 0;
            else if (!ReqB && $urandom_range(0, 2) == 0) begin
                ReqB = 1; WrB = 1'($urandom); AddrB = AW'($urandom); DataB = 1'($urandom);
            end
            Reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        Reset = 0; ReqA = 0; ReqB = 0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_bank_arbiter.md
LATCH_BANK_ARBITER -- requirements
Module: latch_bank_arbiter

Interface
REQ-001 Parameter CELLS, default 8, number of 1-bit latch cells in the shared bank; power of two, 2..64.
REQ-002 Parameter STROBE_CYCLES, default 2, clock cycles each WriteEdge/ReadEdge strobe is held high; legal range 1..15.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 ReqA, ReqB  input  1 each  requester A/B transaction request, held high until the matching Ack.
REQ-006 WrA, WrB  input  1 each  1 = write, 0 = read; sampled with the request.
REQ-007 AddrA, AddrB  input  log2(CELLS) each  target cell index.
REQ-008 DataA, DataB  input  1 each  write data.
REQ-009 AckA, AckB  output  1 each  one-cycle completion pulse.
REQ-010 RdData  output  1  read result, valid in the Ack cycle, held until the next Ack.
REQ-011 Busy  output  1  high in every non-IDLE state.
REQ-012 VerifyErr  output  1  write-verify mismatch pulse, coincident with Ack.
REQ-013 LatchData  output  1  shared inputData drive to all cells.
REQ-014 WriteEdge, ReadEdge  output  CELLS each  per-cell strobes, one-hot or zero.
REQ-015 LatchOut  input  CELLS  outputData of each cell.

Function
REQ-016 FSM states IDLE, SETUP, WSTROBE, HOLD, RSTROBE, CAPTURE, DONE; reset state IDLE.
REQ-017 In IDLE with any Req high, the grant, opcode, address and data are registered and the FSM advances next cycle; Req in non-IDLE states is ignored.
REQ-018 Arbitration round-robin: single requester wins; both high -> the requester not granted last wins; LastGrant resets to B so A wins the first tie.
REQ-019 Write: IDLE -> SETUP (LatchData driven, strobes low, 1 cycle) -> WSTROBE (WriteEdge[addr] high, STROBE_CYCLES cycles) -> HOLD (LatchData held, strobes low, 1 cycle) -> DONE.
REQ-020 Read: IDLE -> RSTROBE (ReadEdge[addr] high, STROBE_CYCLES cycles) -> CAPTURE (ReadEdge[addr] still high, LatchOut[addr] registered) -> DONE.
REQ-021 Latency with request accepted in cycle 0: write Ack in cycle STROBE_CYCLES+3, read Ack in cycle STROBE_CYCLES+2.
REQ-022 DONE asserts the granted Ack for exactly one cycle, updates RdData on reads, then returns to IDLE; no back-to-back grant without an intervening IDLE cycle.
REQ-023 WriteEdge and ReadEdge never high in the same cycle; at most one bit of either vector high at a time.
REQ-024 LatchData is stable from SETUP through HOLD; it holds its last value outside write transactions.
REQ-025 Requester dropping Req after grant does not abort the transaction; Ack is still issued.
REQ-026 The strobe counter is log2-sized for STROBE_CYCLES, reloads on every state entry, and never wraps inside a strobe.

Reset
REQ-027 Reset high at a clock edge forces IDLE, all strobes, Acks, Busy, VerifyErr, LatchData and RdData to 0, and LastGrant to B.
REQ-028 Reset mid-transaction aborts it: strobes drop at that edge and no Ack is issued for the aborted transaction.

Configuration
REQ-029 Macro LATCH_ARB_VERIFY_EN defined: a write proceeds HOLD -> RSTROBE -> CAPTURE -> DONE on the same cell; VerifyErr pulses with Ack if the captured value differs from the write data; RdData takes the captured value; write Ack in cycle 2*STROBE_CYCLES+4.
REQ-030 Macro undefined: no verify path, VerifyErr tied 0, write timing per REQ-021.

Verification
REQ-031 Reset, ReqA=1 WrA=1 AddrA=3 DataA=1, STROBE_CYCLES=2 -> WriteEdge=8'h08 in cycles 2-3, AckA in cycle 5, Busy cycles 1-5.
REQ-032 Cell 3 model holds 1; ReqB=1 WrB=0 AddrB=3 -> ReadEdge=8'h08 cycles 1-3, AckB and RdData=1 in cycle 4.
REQ-033 ReqA and ReqB high together for three transactions -> grants A, B, A; no grant in cycles with Busy high.
REQ-034 Reset asserted during WSTROBE of a write -> WriteEdge=0 next cycle, no AckA, next request accepted normally.
REQ-035 LATCH_ARB_VERIFY_EN, write 1 to cell 5 with model stuck at 0 -> AckA with VerifyErr=1 in cycle 8, RdData=0.
